ntt_host_loader: RTL

//  Host-side BRAM port-B manager for the NTT engine (ntt_bram owns port A).

---
 rtl/ntt_host_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ntt_host_loader.sv
// BRAM port-B manager for the NTT engine: loads x then W from a host stream, runs the
// engine, then streams the N result words back out. One pass per reset.
module ntt_host_loader #(
  parameter int N      = 64,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 13,
  parameter int X_BASE = 0,
  parameter int W_BASE = 64,
  parameter int Y_BASE = 4160,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              bram_en,
  output logic              bram_we,
  output logic              ntt_rst,
  input  logic              ntt_done,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  localparam int TOTAL = N + N * N;
  localparam int PTR_W = $clog2(TOTAL + 1);
  localparam int K_W   = (N > 1) ? $clog2(N) : 1;

  localparam logic [PTR_W-1:0]  PTR_X_LAST = PTR_W'(W_BASE - X_BASE - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(TOTAL - 1);
  localparam logic [PTR_W-1:0]  PTR_END    = PTR_W'(TOTAL);
  localparam logic [K_W-1:0]    K_LAST     = K_W'(N - 1);
  localparam logic [ADDR_W-1:0] X_BASE_A   = ADDR_W'(X_BASE);
  localparam logic [ADDR_W-1:0] Y_BASE_A   = ADDR_W'(Y_BASE);
  localparam logic [2:0]        LAT        = 3'(RD_LAT);

  typedef enum logic [2:0] {S_LOAD_X, S_LOAD_W, S_RUN, S_UNLOAD, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic [K_W-1:0]    k, k_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic              rd_pend, rd_pend_nxt;
  logic              s_ready_nxt, bram_en_nxt, bram_we_nxt, ntt_rst_nxt;
  logic              m_valid_nxt, busy_nxt, done_nxt;
  logic [ADDR_W-1:0] bram_addr_nxt;
  logic [DATA_W-1:0] bram_din_nxt, m_data_nxt;
  logic              accept;

  assign accept = s_valid & s_ready;

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    k_nxt         = k;
    cnt_nxt       = cnt;
    rd_pend_nxt   = rd_pend;
    s_ready_nxt   = 1'b0;
    bram_en_nxt   = 1'b0;
    bram_we_nxt   = 1'b0;
    bram_addr_nxt = bram_addr;
    bram_din_nxt  = bram_din;
    m_data_nxt    = m_data;
    m_valid_nxt   = m_valid;

    case (state)
      S_LOAD_X, S_LOAD_W: begin
        // Accepted beat becomes a write one cycle later; ptr spans x and W contiguously
        if (accept) begin
          ptr_nxt       = ptr + 1'b1;
          bram_addr_nxt = X_BASE_A + ADDR_W'(ptr);
          bram_din_nxt  = s_data;
          bram_en_nxt   = 1'b1;
          bram_we_nxt   = 1'b1;
          if (state == S_LOAD_X && ptr == PTR_X_LAST) state_nxt = S_LOAD_W;
        end
        if (ptr == PTR_END) state_nxt = S_RUN;
        s_ready_nxt = (ptr != PTR_END) && !(accept && ptr == PTR_LAST);
      end
      S_RUN: begin
        if (ntt_done) begin
          state_nxt     = S_UNLOAD;
          bram_addr_nxt = Y_BASE_A + ADDR_W'(k);
          bram_en_nxt   = 1'b1;
          rd_pend_nxt   = 1'b1;
          cnt_nxt       = LAT;
        end
      end
      S_UNLOAD: begin
        // Read issued, count down the BRAM latency, latch, then hold until taken
        if (rd_pend) begin
          if (cnt == 3'd0) begin
            m_data_nxt  = bram_dout;
            m_valid_nxt = 1'b1;
            rd_pend_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt - 3'd1;
          end
        end else if (m_valid && m_ready) begin
          m_valid_nxt = 1'b0;
          if (k == K_LAST) begin
            state_nxt = S_DONE;
          end else begin
            k_nxt         = k + 1'b1;
            bram_addr_nxt = Y_BASE_A + ADDR_W'(k + 1'b1);
            bram_en_nxt   = 1'b1;
            rd_pend_nxt   = 1'b1;
            cnt_nxt       = LAT;
          end
        end
      end
      default: ;
    endcase

    busy_nxt    = (state_nxt != S_DONE);
    done_nxt    = (state_nxt == S_DONE);
    ntt_rst_nxt = (state_nxt == S_LOAD_X) || (state_nxt == S_LOAD_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LOAD_X;
      ptr       <= '0;
      k         <= '0;
      cnt       <= '0;
      rd_pend   <= 1'b0;
      s_ready   <= 1'b0;
      bram_en   <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      ntt_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      k         <= k_nxt;
      cnt       <= cnt_nxt;
      rd_pend   <= rd_pend_nxt;
      s_ready   <= s_ready_nxt;
      bram_en   <= bram_en_nxt;
      bram_we   <= bram_we_nxt;
      bram_addr <= bram_addr_nxt;
      bram_din  <= bram_din_nxt;
      m_data    <= m_data_nxt;
      m_valid   <= m_valid_nxt;
      ntt_rst   <= ntt_rst_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule
